// File: rtl/sync_ram_dp_real_if.sv
// Bus bundle for sync_ram_dp_real: write port, read port, clear control and status.
interface sync_ram_dp_real_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int IN_WIDTH   = 16,
  parameter int WIDTH      = 18
);
  logic                         wr_en;
  logic [ADDR_WIDTH-1:0]        wr_addr;
  logic signed [IN_WIDTH-1:0]   wr_data;
  logic                         wr_ready;
  logic                         rd_en;
  logic [ADDR_WIDTH-1:0]        rd_addr;
  logic signed [WIDTH-1:0]      rd_data;
  logic                         rd_valid;
  logic                         clr;
  logic                         busy;
  logic                         sat_flag;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, clr,
    input  wr_ready, rd_data, rd_valid, busy, sat_flag
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, clr,
    output wr_ready, rd_data, rd_valid, busy, sat_flag
  );
endinterface

// File: rtl/sync_ram_dp_real.sv
// Simple dual-port fixed-point RAM: aligned write port, pipelined read port, clear sequencer.
// Define SYNC_RAM_DP_SAT_EN to clamp out-of-range writes and enable the sticky sat_flag.
module sync_ram_dp_real #(
  parameter int ADDR_WIDTH  = 2,
  parameter int IN_WIDTH    = 16,
  parameter int IN_EXP      = -8,
  parameter int WIDTH       = 18,
  parameter int EXP         = -12,
  parameter int OUT_REG     = 0,
  parameter int WRITE_FIRST = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  sync_ram_dp_real_if.slave bus
);
  localparam int DEPTH  = 2**ADDR_WIDTH;
  localparam int SH     = IN_EXP - EXP;
  localparam int LSH    = (SH > 0) ? SH : 0;
  localparam int RSH    = (SH < 0) ? -SH : 0;
  localparam int XW     = IN_WIDTH + LSH + WIDTH;
  localparam int STAGES = 1 + OUT_REG;

  typedef logic signed [WIDTH-1:0] word_t;
  typedef struct packed {
    logic                  en;
    logic [ADDR_WIDTH-1:0] addr;
    word_t                 data;
  } wr_req_t;
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic                  busy;

  // ---------------- alignment ----------------
  // XW is wide enough that the shift itself never loses bits; narrowing happens after.
  logic signed [XW-1:0] ext, shifted;
  word_t                aligned;

  assign ext     = {{(XW-IN_WIDTH){bus.wr_data[IN_WIDTH-1]}}, bus.wr_data};
  assign shifted = (ext <<< LSH) >>> RSH;

`ifdef SYNC_RAM_DP_SAT_EN
  localparam word_t W_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam word_t W_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [XW-WIDTH:0] hi;
  logic              ovf;
  logic              sat_q;

  assign hi      = shifted[XW-1:WIDTH-1];
  assign ovf     = !((&hi) || !(|hi));
  assign aligned = ovf ? (shifted[XW-1] ? W_MIN : W_MAX) : word_t'(shifted);

  // clr wins over a same-cycle overflowing write so the flag always restarts clean
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_q <= 1'b0;
    else if (state == IDLE && bus.clr)
      sat_q <= 1'b0;
    else if (state == IDLE && bus.wr_en && ovf)
      sat_q <= 1'b1;
  end

  assign bus.sat_flag = sat_q;
`else
  assign aligned      = word_t'(shifted);
  assign bus.sat_flag = 1'b0;
`endif

  // ---------------- clear FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.clr) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == ADDR_WIDTH'(DEPTH-1))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy         = (state == CLEAR);
  assign bus.busy     = busy;
  assign bus.wr_ready = !busy;

  // ---------------- storage ----------------
  // The clear sequencer owns the write port while busy; user writes are dropped.
  wr_req_t wq;
  word_t   mem [DEPTH];
  word_t   rd_word;

  always_comb begin
    wq = '0;
    if (busy) begin
      wq.en   = 1'b1;
      wq.addr = cnt;
      wq.data = '0;
    end else if (bus.wr_en) begin
      wq.en   = 1'b1;
      wq.addr = bus.wr_addr;
      wq.data = aligned;
    end
  end

  always_ff @(posedge clk) begin
    if (wq.en)
      mem[wq.addr] <= wq.data;
  end

  always_comb begin
    rd_word = mem[bus.rd_addr];
    if (WRITE_FIRST != 0 && wq.en && wq.addr == bus.rd_addr)
      rd_word = wq.data;
  end

  // ---------------- read pipeline ----------------
  logic [STAGES:1]            vld_pipe;
  logic [STAGES:1][WIDTH-1:0] dat_pipe;

  // Data stages only load with a valid token so rd_data holds between results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe <= STAGES'({vld_pipe, bus.rd_en});
      if (bus.rd_en)
        dat_pipe[1] <= rd_word;
      for (int s = 2; s <= STAGES; s++)
        if (vld_pipe[s-1])
          dat_pipe[s] <= dat_pipe[s-1];
    end
  end

  assign bus.rd_data  = dat_pipe[STAGES];
  assign bus.rd_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_sync_ram_dp_real.sv
// Bench for sync_ram_dp_real: directed checks on the default build plus a random
// right-shift / write-first / output-register instance against an array model.
module tb_sync_ram_dp_real;
  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

`ifdef SYNC_RAM_DP_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  sync_ram_dp_real_if #(.ADDR_WIDTH(2), .IN_WIDTH(16), .WIDTH(18)) ia ();
  sync_ram_dp_real_if #(.ADDR_WIDTH(2), .IN_WIDTH(16), .WIDTH(18)) ib ();

  sync_ram_dp_real #(.ADDR_WIDTH(2), .IN_WIDTH(16), .IN_EXP(-8), .WIDTH(18), .EXP(-12),
                     .OUT_REG(0), .WRITE_FIRST(0))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));

  sync_ram_dp_real #(.ADDR_WIDTH(2), .IN_WIDTH(16), .IN_EXP(-14), .WIDTH(18), .EXP(-12),
                     .OUT_REG(1), .WRITE_FIRST(1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic a_set(input bit we, input int wa, input int wd, input bit re, input int ra);
    ia.wr_en = we; ia.wr_addr = 2'(wa); ia.wr_data = 16'(wd);
    ia.rd_en = re; ia.rd_addr = 2'(ra); ia.clr = 1'b0;
  endtask

  task automatic b_set(input bit we, input int wa, input int wd, input bit re, input int ra);
    ib.wr_en = we; ib.wr_addr = 2'(wa); ib.wr_data = 16'(wd);
    ib.rd_en = re; ib.rd_addr = 2'(ra); ib.clr = 1'b0;
  endtask

  // Value stored for IN_EXP=-14 into EXP=-12: divide by 4, rounding toward -inf.
  function automatic int fdiv4(input int v);
    int r;
    r = ((v % 4) + 4) % 4;
    return (v - r) / 4;
  endfunction

  int mdl [4];
  int cur_d, prev_d, last_d;
  bit cur_v, prev_v;
  bit wen, ren;
  int wa, ra, wd;

  initial begin
    rst_n = 1'b0;
    a_set(0, 0, 0, 0, 0);
    b_set(0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("rst_busy", ia.busy, 0);
    chk("rst_wr_ready", ia.wr_ready, 1);
    chk("rst_rd_valid", ia.rd_valid, 0);
    chk("rst_rd_data", ia.rd_data, 0);
    chk("rst_sat_flag", ia.sat_flag, 0);
    chk("rst_b_rd_valid", ib.rd_valid, 0);
    chk("rst_b_rd_data", ib.rd_data, 0);
    rst_n = 1'b1;
    tick();

    // 1.5 into addr 2, read back with one cycle latency
    a_set(1, 2, 384, 0, 0); tick();
    a_set(0, 0, 0, 1, 2);   tick();
    a_set(0, 0, 0, 0, 0);
    chk("rd_valid_lat", ia.rd_valid, 1);
    chk("rd_1p5", ia.rd_data, 6144);
    tick();
    chk("rd_valid_pulse", ia.rd_valid, 0);
    chk("rd_hold", ia.rd_data, 6144);

    // 100.0 overflows the storage format
    a_set(1, 1, 25600, 0, 0); tick();
    a_set(0, 0, 0, 1, 1);     tick();
    chk("ovf_pos", ia.rd_data, SAT ? 131071 : -114688);
    chk("ovf_flag", ia.sat_flag, SAT ? 1 : 0);
    a_set(1, 1, -32768, 0, 0); tick();
    a_set(0, 0, 0, 1, 1);      tick();
    chk("ovf_neg", ia.rd_data, SAT ? -131072 : 0);

    // same-address read during write, read-first instance
    a_set(1, 3, 16, 0, 0);  tick();
    a_set(1, 3, 384, 1, 3); tick();
    chk("rdw_old", ia.rd_data, 256);
    a_set(0, 0, 0, 1, 3);   tick();
    chk("rdw_after", ia.rd_data, 6144);

    // clear sequence with a dropped write in its last busy cycle
    for (int k = 0; k < 4; k++) begin
      a_set(1, k, 100 * (k + 1), 0, 0); tick();
    end
    a_set(0, 0, 0, 0, 0); ia.clr = 1'b1; tick();
    ia.clr = 1'b0;
    chk("clr_busy_0", ia.busy, 1);
    chk("clr_rdy_0", ia.wr_ready, 0);
    for (int c = 1; c < 4; c++) begin
      if (c == 3) a_set(1, 0, 999, 0, 0);
      tick();
      a_set(0, 0, 0, 0, 0);
      chk("clr_busy_n", ia.busy, 1);
      chk("clr_rdy_n", ia.wr_ready, 0);
    end
    tick();
    chk("clr_done_busy", ia.busy, 0);
    chk("clr_done_rdy", ia.wr_ready, 1);
    for (int k = 0; k < 4; k++) begin
      a_set(0, 0, 0, 1, k); tick();
      chk("clr_zero_valid", ia.rd_valid, 1);
      chk("clr_zero", ia.rd_data, 0);
    end
    a_set(0, 0, 0, 0, 0);
    chk("clr_sat_flag", ia.sat_flag, 0);

    // asynchronous reset in the second cycle of a clear
    for (int k = 0; k < 4; k++) begin
      a_set(1, k, 10 * (k + 1), 0, 0); tick();
    end
    a_set(0, 0, 0, 0, 0); ia.clr = 1'b1; tick();
    a_set(0, 0, 0, 1, 3); tick();
    a_set(0, 0, 0, 0, 0);
    chk("mid_busy", ia.busy, 1);
    chk("mid_valid", ia.rd_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", ia.busy, 0);
    chk("async_valid", ia.rd_valid, 0);
    chk("async_rdy", ia.wr_ready, 1);
    chk("async_data", ia.rd_data, 0);
    tick();
    rst_n = 1'b1;
    tick();
    a_set(0, 0, 0, 1, 0); tick();
    chk("part_addr0", ia.rd_data, 0);
    a_set(0, 0, 0, 1, 2); tick();
    chk("part_addr2", ia.rd_data, 480);
    a_set(0, 0, 0, 1, 3); tick();
    chk("part_addr3", ia.rd_data, 640);
    a_set(0, 0, 0, 0, 0);

    // write-first, two-cycle read instance
    b_set(1, 3, 1024, 0, 0); tick();
    b_set(1, 3, 384, 1, 3);  tick();
    b_set(0, 0, 0, 0, 0);
    chk("b_lat_valid0", ib.rd_valid, 0);
    chk("b_lat_hold", ib.rd_data, 0);
    tick();
    chk("b_wf_valid", ib.rd_valid, 1);
    chk("b_wf_data", ib.rd_data, 96);
    tick();
    chk("b_wf_pulse", ib.rd_valid, 0);
    last_d = 96;

    for (int k = 0; k < 4; k++) begin
      wd = int'($signed(16'($urandom)));
      mdl[k] = fdiv4(wd);
      b_set(1, k, wd, 0, 0); tick();
    end
    b_set(0, 0, 0, 0, 0); tick();
    prev_v = 1'b0;
    prev_d = 0;

    for (int i = 0; i < 120; i++) begin
      wen = ($urandom_range(0, 1) == 1);
      ren = ($urandom_range(0, 3) != 0);
      wa  = int'($urandom_range(0, 3));
      ra  = int'($urandom_range(0, 3));
      wd  = int'($signed(16'($urandom)));
      cur_v = ren;
      cur_d = (wen && wa == ra) ? fdiv4(wd) : mdl[ra];
      if (wen) mdl[wa] = fdiv4(wd);
      b_set(wen, wa, wd, ren, ra); tick();
      if (prev_v) last_d = prev_d;
      chk("rnd_valid", ib.rd_valid, 32'(prev_v));
      chk("rnd_data", ib.rd_data, last_d);
      prev_v = cur_v;
      prev_d = cur_d;
    end
    b_set(0, 0, 0, 0, 0); tick();
    if (prev_v) last_d = prev_d;
    chk("rnd_tail_valid", ib.rd_valid, 32'(prev_v));
    chk("rnd_tail_data", ib.rd_data, last_d);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
